// File: rtl/plusarg_watchdog.sv
// Run watchdog: flags an overlong run (total-cycle budget) or a hung one
// (stall budget: consecutive cycles with work pending and no kick).

module plusarg_watchdog #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] limit_total,
  input  logic [WIDTH-1:0] limit_stall,
  input  logic             enable,
  input  logic             pending,
  input  logic             kick,
  output logic             timeout,
  output logic             fire,
  output logic [1:0]       cause,
  output logic [WIDTH-1:0] total_count,
  output logic [WIDTH-1:0] stall_count
);

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    EXPIRED = 2'd2
  } stall_state_t;

  stall_state_t     state;
  stall_state_t     state_next;
  logic [WIDTH-1:0] lim_total;
  logic [WIDTH-1:0] lim_stall;
  logic [WIDTH-1:0] total_next;
  logic [WIDTH-1:0] stall_next;
  logic             total_hit;
  logic             stall_hit;
  logic [1:0]       cause_next;

  // Saturating total counter; the hit fires only on the edge that reaches the limit.
  always_comb begin
    total_next = total_count;
    total_hit  = 1'b0;
    if (enable && (total_count != ALL_ONES)) begin
      total_next = total_count + ONE;
      total_hit  = (lim_total != ZERO) && (total_next == lim_total);
    end else begin
      total_next = total_count;
    end
  end

  // Stall FSM next-state; a kick outranks both a pending drop and an expiry.
  always_comb begin
    state_next = state;
    stall_next = stall_count;
    stall_hit  = 1'b0;
    case (state)
      IDLE: begin
        stall_next = ZERO;
        if (enable && pending && (lim_stall != ZERO)) begin
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (!enable) begin
          state_next = WAIT;
        end else if (kick) begin
          stall_next = ZERO;
        end else if (!pending) begin
          stall_next = ZERO;
          state_next = IDLE;
        end else begin
          stall_next = stall_count + ONE;
          if (stall_next == lim_stall) begin
            state_next = EXPIRED;
            stall_hit  = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      EXPIRED: begin
        state_next = EXPIRED;
      end
      default: begin
        state_next = IDLE;
        stall_next = ZERO;
      end
    endcase
  end

  // Sticky cause accumulation.
  always_comb begin
    cause_next = cause | {total_hit, stall_hit};
  end

  // State and output registers; limits are only sampled while in reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      lim_total   <= limit_total;
      lim_stall   <= limit_stall;
      state       <= IDLE;
      total_count <= ZERO;
      stall_count <= ZERO;
      cause       <= 2'b00;
      timeout     <= 1'b0;
      fire        <= 1'b0;
    end else begin
      state       <= state_next;
      total_count <= total_next;
      stall_count <= stall_next;
      cause       <= cause_next;
      timeout     <= |cause_next;
      fire        <= (|cause_next) & ~timeout;
    end
  end

  plusarg_watchdog_checker #(.WIDTH(WIDTH)) u_checker (
    .clock       (clock),
    .reset       (reset),
    .lim_stall   (lim_stall),
    .timeout     (timeout),
    .fire        (fire),
    .cause       (cause),
    .stall_count (stall_count)
  );

endmodule

// Invariants on the registered outputs.
module plusarg_watchdog_checker #(
  parameter int WIDTH = 32
) (
  input logic             clock,
  input logic             reset,
  input logic [WIDTH-1:0] lim_stall,
  input logic             timeout,
  input logic             fire,
  input logic [1:0]       cause,
  input logic [WIDTH-1:0] stall_count
);

  a_fire_has_timeout: assert property (@(posedge clock) disable iff (reset)
    fire |-> timeout);

  a_timeout_is_cause: assert property (@(posedge clock) disable iff (reset)
    timeout == (cause != 2'b00));

  a_stall_bounded: assert property (@(posedge clock) disable iff (reset)
    stall_count <= lim_stall);

endmodule

// File: tb/tb_plusarg_watchdog.sv
// Randomized and directed bench for plusarg_watchdog with a per-cycle reference model.

module tb_plusarg_watchdog;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] limit_total;
  logic [W-1:0] limit_stall;
  logic         enable;
  logic         pending;
  logic         kick;
  logic         timeout;
  logic         fire;
  logic [1:0]   cause;
  logic [W-1:0] total_count;
  logic [W-1:0] stall_count;

  int checks = 0;
  int errors = 0;
  int fire_seen = 0;
  int max_stall = 0;

  // Reference model state (plain integers and flags).
  bit model_on = 1'b0;
  int m_lim_total, m_lim_stall;
  int m_total, m_stall, m_cause;
  bit m_tracking, m_expired, m_timeout, m_fire;

  plusarg_watchdog #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .limit_total (limit_total),
    .limit_stall (limit_stall),
    .enable      (enable),
    .pending     (pending),
    .kick        (kick),
    .timeout     (timeout),
    .fire        (fire),
    .cause       (cause),
    .total_count (total_count),
    .stall_count (stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on each rising edge from the inputs; outputs compared 1 time unit later.
  always @(posedge clock) begin
    if (reset) begin
      model_on    = 1'b1;
      m_lim_total = int'(limit_total);
      m_lim_stall = int'(limit_stall);
      m_total = 0; m_stall = 0; m_cause = 0;
      m_tracking = 1'b0; m_expired = 1'b0; m_timeout = 1'b0; m_fire = 1'b0;
    end else begin
      if (enable && m_total < MAXV) begin
        m_total = m_total + 1;
        if (m_lim_total != 0 && m_total == m_lim_total) m_cause = m_cause | 2;
      end
      if (enable && !m_expired) begin
        if (!m_tracking) begin
          if (pending && m_lim_stall != 0) m_tracking = 1'b1;
        end else if (kick) begin
          m_stall = 0;
        end else if (!pending) begin
          m_stall = 0;
          m_tracking = 1'b0;
        end else begin
          m_stall = m_stall + 1;
          if (m_stall == m_lim_stall) begin
            m_expired = 1'b1;
            m_cause = m_cause | 1;
          end
        end
      end
      m_fire    = (m_cause != 0) && !m_timeout;
      m_timeout = (m_cause != 0);
    end
    #1;
    if (model_on) begin
      chk("timeout", int'(timeout), int'(m_timeout));
      chk("fire", int'(fire), int'(m_fire));
      chk("cause", int'(cause), m_cause);
      chk("total_count", int'(total_count), m_total);
      chk("stall_count", int'(stall_count), m_stall);
      if (fire) fire_seen++;
      if (int'(stall_count) > max_stall) max_stall = int'(stall_count);
    end
  end

  task automatic do_reset(input int lt, input int ls);
    reset = 1'b1; enable = 1'b0; pending = 1'b0; kick = 1'b0;
    limit_total = W'(lt); limit_stall = W'(ls);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    fire_seen = 0;
    max_stall = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_fire"}, int'(fire), 0);
    chk({tag, "_cause"}, int'(cause), 0);
    chk({tag, "_total"}, int'(total_count), 0);
    chk({tag, "_stall"}, int'(stall_count), 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; pending = 1'b0; kick = 1'b0;
    limit_total = '0; limit_stall = '0;
    @(negedge clock);

    // Total budget of 100.
    do_reset(100, 0);
    chk_zero("rst");
    enable = 1'b1;
    repeat (100) @(negedge clock);
    chk("tot_count100", int'(total_count), 100);
    chk("tot_cause", int'(cause), 2);
    chk("tot_timeout", int'(timeout), 1);
    chk("tot_fire", int'(fire), 1);
    repeat (2) @(negedge clock);
    chk("tot_count102", int'(total_count), 102);
    chk("tot_fire_once", fire_seen, 1);

    // Stall budget of 5, then a late kick.
    do_reset(0, 5);
    enable = 1'b1; pending = 1'b1;
    repeat (6) @(negedge clock);
    chk("stl_count", int'(stall_count), 5);
    chk("stl_cause", int'(cause), 1);
    chk("stl_fire", int'(fire), 1);
    kick = 1'b1; pending = 1'b0;
    repeat (3) @(negedge clock);
    kick = 1'b0;
    chk("stl_hold", int'(stall_count), 5);
    chk("stl_fire_once", fire_seen, 1);

    // Reset out of EXPIRED and expire again.
    do_reset(0, 5);
    chk_zero("rexp");
    enable = 1'b1; pending = 1'b1;
    repeat (6) @(negedge clock);
    chk("rexp_fire", int'(fire), 1);
    chk("rexp_fire_cnt", fire_seen, 1);

    // Kick every 4th cycle.
    do_reset(0, 5);
    enable = 1'b1; pending = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      kick = (i % 4 == 3);
      @(negedge clock);
    end
    kick = 1'b0;
    chk("kick_timeout", int'(timeout), 0);
    chk("kick_max_ok", int'(max_stall <= 4), 1);

    // Kick on the would-be expiring cycle.
    do_reset(0, 5);
    enable = 1'b1; pending = 1'b1;
    repeat (5) @(negedge clock);
    chk("k5_pre", int'(stall_count), 4);
    kick = 1'b1;
    @(negedge clock);
    kick = 1'b0;
    chk("k5_clear", int'(stall_count), 0);
    chk("k5_timeout", int'(timeout), 0);
    repeat (5) @(negedge clock);
    chk("k5_later_cause", int'(cause), 1);

    // Enable freeze then pending drop.
    do_reset(0, 10);
    enable = 1'b1; pending = 1'b1;
    repeat (4) @(negedge clock);
    enable = 1'b0;
    repeat (20) @(negedge clock);
    chk("frz_hold", int'(stall_count), 3);
    enable = 1'b1; pending = 1'b0;
    @(negedge clock);
    chk("frz_drop", int'(stall_count), 0);

    // Limit captured during reset only.
    do_reset(50, 0);
    limit_total = W'(10);
    enable = 1'b1;
    repeat (10) @(negedge clock);
    chk("cap_no_early", int'(timeout), 0);
    repeat (40) @(negedge clock);
    chk("cap_count", int'(total_count), 50);
    chk("cap_cause", int'(cause), 2);

    // Both checks expiring together.
    do_reset(6, 5);
    enable = 1'b1; pending = 1'b1;
    repeat (6) @(negedge clock);
    chk("both_cause", int'(cause), 3);
    @(negedge clock);
    chk("both_fire_once", fire_seen, 1);

    // lim_stall = 1.
    do_reset(0, 1);
    enable = 1'b1; pending = 1'b1;
    repeat (2) @(negedge clock);
    chk("ls1_count", int'(stall_count), 1);
    chk("ls1_cause", int'(cause), 1);

    // Saturation and an all-ones limit.
    do_reset(0, 0);
    enable = 1'b1;
    repeat (300) @(negedge clock);
    chk("sat_count", int'(total_count), MAXV);
    chk("sat_timeout", int'(timeout), 0);
    do_reset(MAXV, 0);
    enable = 1'b1;
    repeat (MAXV) @(negedge clock);
    chk("max_cause", int'(cause), 2);

    // Randomized rounds, including limit changes after reset.
    for (int r = 0; r < 12; r++) begin
      do_reset(int'($urandom_range(0, 60)), int'($urandom_range(0, 8)));
      for (int c = 0; c < 250; c++) begin
        enable  = ($urandom_range(0, 3) != 0);
        pending = ($urandom_range(0, 9) < 7);
        kick    = ($urandom_range(0, 9) < 2);
        if ($urandom_range(0, 31) == 0) begin
          limit_total = W'($urandom_range(0, 60));
          limit_stall = W'($urandom_range(0, 8));
        end
        @(negedge clock);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
